// File: rtl/bit_serializer.sv
// bit_serializer: double-buffered parallel-to-serial converter, one bit per clock
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   sync_clr  synchronous clear of the in-flight and queued words
//   in_data   parallel word, in_valid/in_ready handshake
//   ser_out   serial bit, forced to 0 when ser_valid is low
//   ser_valid ser_out carries a data bit
//   ser_last  final bit of the current word
//   busy      a word is shifting or queued
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nx;
    logic [WIDTH-1:0] shifter, shifter_nx, hold, hold_nx;
    logic hold_full, hold_full_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic xfer, load_pt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            shifter   <= shifter_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
            cnt       <= cnt_nx;
        end
    end

    always_comb begin
        xfer         = in_valid && !hold_full && !sync_clr;
        load_pt      = state == IDLE || cnt == LAST;
        state_nx     = state;
        shifter_nx   = shifter;
        hold_nx      = hold;
        hold_full_nx = hold_full;
        cnt_nx       = cnt;
        if (sync_clr) begin
            state_nx     = IDLE;
            shifter_nx   = '0;
            hold_full_nx = 1'b0;
            cnt_nx       = '0;
        end else if (load_pt) begin
            // A queued word always wins the load slot; in_ready is low then, so no new word can compete.
            cnt_nx = '0;
            if (hold_full) begin
                shifter_nx   = hold;
                hold_full_nx = 1'b0;
                state_nx     = SHIFT;
            end else if (xfer) begin
                shifter_nx = in_data;
                state_nx   = SHIFT;
            end else begin
                state_nx = IDLE;
            end
        end else begin
            cnt_nx     = cnt + 1'b1;
            shifter_nx = MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0} : {1'b0, shifter[WIDTH-1:1]};
            if (xfer) begin
                hold_nx      = in_data;
                hold_full_nx = 1'b1;
            end
        end
    end

    assign in_ready  = !hold_full;
    assign ser_valid = state == SHIFT;
    assign ser_out   = ser_valid && (MSB_FIRST ? shifter[WIDTH-1] : shifter[0]);
    assign ser_last  = ser_valid && cnt == LAST;
    assign busy      = ser_valid || hold_full;
endmodule
